// File: rtl/colour_bbox_pkg.sv
// Shared types and constants for the colour bounding-box tracker.
package colour_bbox_pkg;

  localparam int MAX_COLOURS  = 8;
  localparam int BBOX_COORD_W = 11;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef struct packed {
    logic [BBOX_COORD_W-1:0] ymin;
    logic [BBOX_COORD_W-1:0] xmin;
    logic [BBOX_COORD_W-1:0] ymax;
    logic [BBOX_COORD_W-1:0] xmax;
  } bbox_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_VIDEO,
    ST_OTHER
  } state_t;

  // Word addresses on the Avalon-MM slave
  localparam logic [5:0] ADDR_THRESH_BASE = 6'h00;
  localparam logic [5:0] ADDR_RESULT_BASE = 6'h10;
  localparam logic [5:0] ADDR_FRAME_COUNT = 6'h20;
  localparam logic [5:0] ADDR_VALID_MASK  = 6'h21;

  // Overlay colours; the last element listed is index 0
  localparam logic [MAX_COLOURS-1:0][23:0] PALETTE = {
    24'h000000,  // 7
    24'hFFFFFF,  // 6
    24'h0000FF,  // 5
    24'h00FF00,  // 4
    24'hFF0000,  // 3
    24'hFFFF00,  // 2
    24'h00FFFF,  // 1
    24'hFF00FF   // 0
  };

  // One corner of a box as seen by the Nios: {ymin/ymax at 26:16, xmin/xmax at 10:0}
  function automatic logic [31:0] pack_corner(input logic [BBOX_COORD_W-1:0] y,
                                              input logic [BBOX_COORD_W-1:0] x);
    return {5'd0, y, 5'd0, x};
  endfunction

endpackage

// File: rtl/colour_window_match.sv
// One colour window: RGB range compare, per-frame bounding-box accumulator
// and the result register that holds the last completed frame's box.
module colour_window_match
  import colour_bbox_pkg::*;
#(
  parameter int COORD_W = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  pixel_t             lo,
  input  pixel_t             hi,
  input  pixel_t             pixel,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               clear,
  input  logic               update,
  input  logic               latch,
  output logic               match,
  output bbox_t              result,
  output logic               result_hit
);

  logic [COORD_W-1:0] xmin_q, ymin_q, xmax_q, ymax_q;
  logic [COORD_W-1:0] xmin_d, ymin_d, xmax_d, ymax_d;
  logic               hit_q, hit_d;

  // Inclusive unsigned range test on all three channels
  always_comb begin
    match = (pixel.r >= lo.r) && (pixel.r <= hi.r) &&
            (pixel.g >= lo.g) && (pixel.g <= hi.g) &&
            (pixel.b >= lo.b) && (pixel.b <= hi.b);
  end

  // Next accumulator values including the current beat, so an EOP beat's
  // own pixel is part of the latched result
  always_comb begin
    xmin_d = xmin_q;
    ymin_d = ymin_q;
    xmax_d = xmax_q;
    ymax_d = ymax_q;
    hit_d  = hit_q;
    if (update && match) begin
      if (x < xmin_q) xmin_d = x;
      if (y < ymin_q) ymin_d = y;
      if (x > xmax_q) xmax_d = x;
      if (y > ymax_q) ymax_d = y;
      hit_d = 1'b1;
    end
  end

  // Accumulate during the frame, copy to the result register at video EOP
  always_ff @(posedge clk) begin
    if (reset) begin
      xmin_q     <= '1;
      ymin_q     <= '1;
      xmax_q     <= '0;
      ymax_q     <= '0;
      hit_q      <= 1'b0;
      result     <= '0;
      result_hit <= 1'b0;
    end else begin
      if (clear) begin
        xmin_q <= '1;
        ymin_q <= '1;
        xmax_q <= '0;
        ymax_q <= '0;
        hit_q  <= 1'b0;
      end else begin
        xmin_q <= xmin_d;
        ymin_q <= ymin_d;
        xmax_q <= xmax_d;
        ymax_q <= ymax_d;
        hit_q  <= hit_d;
      end
      if (latch) begin
        result_hit <= hit_d;
        if (hit_d) begin
          result.ymin <= BBOX_COORD_W'(ymin_d);
          result.xmin <= BBOX_COORD_W'(xmin_d);
          result.ymax <= BBOX_COORD_W'(ymax_d);
          result.xmax <= BBOX_COORD_W'(xmax_d);
        end else begin
          result <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/colour_bbox_tracker.sv
// Streaming RGB colour detector on an Avalon-ST video path: one-stage
// pass-through with backpressure, per-colour bounding boxes per frame,
// optional palette overlay, and an Avalon-MM register slave.
module colour_bbox_tracker
  import colour_bbox_pkg::*;
#(
  parameter int IMAGE_W     = 640,
  parameter int IMAGE_H     = 480,
  parameter int NUM_COLOURS = 4,
  parameter int COORD_W     = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] sink_data,
  input  logic        sink_valid,
  input  logic        sink_sop,
  input  logic        sink_eop,
  output logic        sink_ready,
  output logic [23:0] source_data,
  output logic        source_valid,
  output logic        source_sop,
  output logic        source_eop,
  input  logic        source_ready,
  input  logic [5:0]  s_address,
  input  logic        s_write,
  input  logic        s_read,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  input  logic        mode
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMAGE_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMAGE_H - 1);

  state_t             state;
  logic [COORD_W-1:0] x_q, y_q;
  pixel_t             lo_q [MAX_COLOURS];
  pixel_t             hi_q [MAX_COLOURS];
  logic [MAX_COLOURS-1:0] match;
  logic [MAX_COLOURS-1:0] result_hit;
  bbox_t              result [MAX_COLOURS];
  logic [31:0]        frame_count;
  logic [31:0]        rd_data;
  logic [2:0]         rd_k;
  logic [23:0]        out_data;
  logic               accept, is_video_hdr, video_clear, video_beat, video_latch, pass;
  logic               thresh_sel;
  logic               unused_wdata;

  // The top byte of MM write data has no destination
  assign unused_wdata = ^s_writedata[31:24];

  assign sink_ready   = !source_valid || source_ready;
  assign accept       = sink_valid && sink_ready;
  assign is_video_hdr = (sink_data[3:0] == 4'h0);
  assign video_clear  = accept && sink_sop && is_video_hdr;
  assign video_beat   = accept && !sink_sop && (state == ST_VIDEO);
  assign video_latch  = video_beat && sink_eop;
  // After reset nothing is forwarded until a packet starts cleanly
  assign pass         = !((state == ST_IDLE) && !sink_sop);
  assign thresh_sel   = (s_address[5:4] == ADDR_THRESH_BASE[5:4]) &&
                        (int'(s_address[3:1]) < NUM_COLOURS);

  genvar k;
  generate
    for (k = 0; k < MAX_COLOURS; k++) begin : g_win
      if (k < NUM_COLOURS) begin : g_used
        colour_window_match #(.COORD_W(COORD_W)) u_win (
          .clk        (clk),
          .reset      (reset),
          .lo         (lo_q[k]),
          .hi         (hi_q[k]),
          .pixel      (pixel_t'(sink_data)),
          .x          (x_q),
          .y          (y_q),
          .clear      (video_clear),
          .update     (video_beat),
          .latch      (video_latch),
          .match      (match[k]),
          .result     (result[k]),
          .result_hit (result_hit[k])
        );
      end else begin : g_absent
        assign match[k]      = 1'b0;
        assign result[k]     = '0;
        assign result_hit[k] = 1'b0;
      end
    end
  endgenerate

  // Overlay: lowest-numbered matching window wins, header and non-video beats untouched
  always_comb begin
    out_data = sink_data;
    if (mode && video_beat) begin
      for (int i = NUM_COLOURS - 1; i >= 0; i--) begin
        if (match[i]) out_data = PALETTE[i];
      end
    end
  end

  // Packet classification and pixel coordinate tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      x_q   <= '0;
      y_q   <= '0;
    end else if (accept) begin
      if (sink_sop) begin
        // A new SOP always restarts, even mid-packet
        x_q <= '0;
        y_q <= '0;
        if (sink_eop)          state <= ST_HEADER;
        else if (is_video_hdr) state <= ST_VIDEO;
        else                   state <= ST_OTHER;
      end else begin
        case (state)
          ST_VIDEO: begin
            if (x_q == X_LAST) begin
              x_q <= '0;
              if (y_q != Y_LAST) y_q <= y_q + 1'b1;
            end else begin
              x_q <= x_q + 1'b1;
            end
            if (sink_eop) state <= ST_HEADER;
          end
          ST_OTHER: if (sink_eop) state <= ST_HEADER;
          default: ;
        endcase
      end
    end
  end

  // Single output register stage; contents hold while downstream stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_data  <= '0;
    end else if (sink_ready) begin
      source_valid <= accept && pass;
      if (accept) begin
        source_data <= out_data;
        source_sop  <= sink_sop;
        source_eop  <= sink_eop;
      end
    end
  end

  // Completed video frames
  always_ff @(posedge clk) begin
    if (reset) frame_count <= '0;
    else if (video_latch) frame_count <= frame_count + 32'd1;
  end

  // Threshold registers; reset to an empty range so nothing matches
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_COLOURS; i++) begin
        lo_q[i] <= '1;
        hi_q[i] <= '0;
      end
    end else if (s_write && thresh_sel) begin
      if (s_address[0]) hi_q[s_address[3:1]] <= pixel_t'(s_writedata[23:0]);
      else              lo_q[s_address[3:1]] <= pixel_t'(s_writedata[23:0]);
    end
  end

  // Read decode; unmapped addresses and absent windows read zero
  always_comb begin
    rd_data = '0;
    rd_k    = s_address[3:1];
    if (thresh_sel) begin
      rd_data = {8'h00, s_address[0] ? hi_q[rd_k] : lo_q[rd_k]};
    end else if ((s_address[5:4] == ADDR_RESULT_BASE[5:4]) && (int'(rd_k) < NUM_COLOURS)) begin
      rd_data = s_address[0] ? pack_corner(result[rd_k].ymax, result[rd_k].xmax)
                             : pack_corner(result[rd_k].ymin, result[rd_k].xmin);
    end else if (s_address == ADDR_FRAME_COUNT) begin
      rd_data = frame_count;
    end else if (s_address == ADDR_VALID_MASK) begin
      rd_data = {24'h0, result_hit};
    end
  end

  // Registered read port; a read alongside an EOP latch sees the old value
  always_ff @(posedge clk) begin
    if (reset) s_readdata <= '0;
    else       s_readdata <= s_read ? rd_data : 32'h0;
  end

endmodule

// File: tb/tb_colour_bbox_tracker.sv
// Directed bench for colour_bbox_tracker on an 8x8 image with 4 windows.
module tb_colour_bbox_tracker;

  localparam int IW = 8;
  localparam int IH = 8;
  localparam int NC = 4;
  localparam int CW = 11;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] sink_data;
  logic        sink_valid, sink_sop, sink_eop, sink_ready;
  logic [23:0] source_data;
  logic        source_valid, source_sop, source_eop, source_ready;
  logic [5:0]  s_address;
  logic        s_write, s_read;
  logic [31:0] s_writedata, s_readdata;
  logic        mode;

  int checks = 0;
  int passes = 0;
  logic [25:0] outq[$];
  logic [25:0] expq[$];
  logic [23:0] pix[$];
  bit          rnd_ready = 1'b0;
  logic [25:0] held;
  bit          stalled = 1'b0;

  always #5 clk = ~clk;

  colour_bbox_tracker #(.IMAGE_W(IW), .IMAGE_H(IH), .NUM_COLOURS(NC), .COORD_W(CW)) dut (
    .clk(clk), .reset(reset),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_ready(sink_ready),
    .source_data(source_data), .source_valid(source_valid), .source_sop(source_sop),
    .source_eop(source_eop), .source_ready(source_ready),
    .s_address(s_address), .s_write(s_write), .s_read(s_read), .s_writedata(s_writedata),
    .s_readdata(s_readdata), .mode(mode)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Output monitor plus stall-stability checks, sampled on the falling edge
  always @(negedge clk) begin
    if (reset) begin
      stalled <= 1'b0;
    end else begin
      if (stalled && source_valid)
        check("stall_hold", {6'b0, source_sop, source_eop, source_data}, {6'b0, held});
      if (source_valid && !source_ready) begin
        check("stall_sink_ready", {31'b0, sink_ready}, 32'd0);
        held    <= {source_sop, source_eop, source_data};
        stalled <= 1'b1;
      end else begin
        stalled <= 1'b0;
      end
      if (source_valid && source_ready) outq.push_back({source_sop, source_eop, source_data});
    end
  end

  task automatic send_beat(input logic [23:0] d, input logic s, input logic e);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    sink_data = d; sink_sop = s; sink_eop = e; sink_valid = 1'b1;
    while (!acc) begin
      if (rnd_ready) source_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = sink_ready;
      @(posedge clk); #1;
      n++;
      if (n > 500) begin
        $display("FAIL send_beat: sink_ready stuck at %b, required 1", sink_ready);
        $fatal(1, "sink never ready");
      end
    end
  endtask

  task automatic send_pkt(input logic [3:0] hdr, input bit with_eop);
    logic e;
    e = with_eop && (pix.size() == 0);
    send_beat({20'h0, hdr}, 1'b1, e);
    expq.push_back({1'b1, e, 20'h0, hdr});
    for (int i = 0; i < pix.size(); i++) begin
      e = with_eop && (i == pix.size() - 1);
      send_beat(pix[i], 1'b0, e);
      expq.push_back({1'b0, e, pix[i]});
    end
    sink_valid = 1'b0;
    sink_sop = 1'b0;
    sink_eop = 1'b0;
  endtask

  task automatic drain_compare(input string tag);
    int n;
    n = 0;
    rnd_ready = 1'b0;
    source_ready = 1'b1;
    while (outq.size() < expq.size() && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) begin @(posedge clk); #1; end
    check({tag, "_count"}, outq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < outq.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), {6'b0, outq[i]}, {6'b0, expq[i]});
    outq.delete();
    expq.delete();
  endtask

  task automatic mm_write(input logic [5:0] a, input logic [31:0] d);
    s_address = a; s_writedata = d; s_write = 1'b1;
    @(posedge clk); #1;
    s_write = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] d;
    s_address = a; s_read = 1'b1;
    @(posedge clk); #1;
    s_read = 1'b0;
    d = s_readdata;
    check(tag, d, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; sink_valid = 1'b0; sink_data = '0; sink_sop = 1'b0; sink_eop = 1'b0;
    source_ready = 1'b1; s_address = '0; s_write = 1'b0; s_read = 1'b0; s_writedata = '0;
    mode = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_source_valid", {31'b0, source_valid}, 32'd0);
    check("rst_source_sop",   {31'b0, source_sop},   32'd0);
    check("rst_source_eop",   {31'b0, source_eop},   32'd0);
    check("rst_source_data",  {8'b0, source_data},   32'd0);
    check("rst_readdata",     s_readdata,            32'd0);
    check("rst_sink_ready",   {31'b0, sink_ready},   32'd1);
    check_reg("rst_lo0",   6'h00, 32'h00FFFFFF);
    check_reg("rst_hi0",   6'h01, 32'h00000000);
    check_reg("rst_res0",  6'h10, 32'h0);
    check_reg("rst_fc",    6'h20, 32'h0);
    check_reg("rst_vmask", 6'h21, 32'h0);

    // Default thresholds match nothing: overlay mode still passes the frame unchanged
    mode = 1'b1;
    pix = '{24'h123456, 24'hFF0000, 24'h808080, 24'h000000,
            24'hFFFFFF, 24'h00FF00, 24'hABCDEF, 24'h0000FF};
    send_pkt(4'h0, 1'b1);
    drain_compare("t1");
    check_reg("t1_vmask", 6'h21, 32'h0);
    check_reg("t1_fc",    6'h20, 32'd1);
    check_reg("t1_res0",  6'h10, 32'h0);

    // Single red pixel at (2,1)
    mm_write(6'h00, 32'h00C00000);
    mm_write(6'h01, 32'h00FFFF3F);
    mm_write(6'h08, 32'h00123456);
    check_reg("t2_lo0",     6'h00, 32'h00C00000);
    check_reg("t2_hi0",     6'h01, 32'h00FFFF3F);
    check_reg("t2_absent",  6'h08, 32'h0);
    check_reg("t2_unmapped", 6'h30, 32'h0);
    mode = 1'b0;
    pix.delete();
    for (int i = 0; i < 16; i++) pix.push_back((i == 10) ? 24'hFF0000 : 24'h203040 + 24'(i));
    send_pkt(4'h0, 1'b1);
    drain_compare("t2");
    check_reg("t2_res0_min", 6'h10, 32'h00010002);
    check_reg("t2_res0_max", 6'h11, 32'h00010002);
    check_reg("t2_res1_min", 6'h12, 32'h0);
    check_reg("t2_vmask",    6'h21, 32'h1);
    check_reg("t2_fc",       6'h20, 32'd2);

    // Overlapping windows: window 0 wins priority, window 1 catches the rest
    mm_write(6'h00, 32'h00707070);
    mm_write(6'h01, 32'h00909090);
    mm_write(6'h02, 32'h00000000);
    mm_write(6'h03, 32'h00FFFFFF);
    mode = 1'b1;
    pix = '{24'h808080, 24'h112233, 24'h808080, 24'hFFFFFF};
    send_pkt(4'h0, 1'b1);
    expq[1] = {2'b00, 24'hFF00FF};
    expq[2] = {2'b00, 24'h00FFFF};
    expq[3] = {2'b00, 24'hFF00FF};
    expq[4] = {2'b01, 24'h00FFFF};
    drain_compare("t3");
    check_reg("t3_vmask",    6'h21, 32'h3);
    check_reg("t3_res0_min", 6'h10, 32'h00000000);
    check_reg("t3_res0_max", 6'h11, 32'h00000002);
    check_reg("t3_res1_max", 6'h13, 32'h00000003);
    check_reg("t3_fc",       6'h20, 32'd3);
    mm_write(6'h02, 32'h00FFFFFF);
    mm_write(6'h03, 32'h00000000);

    // Full frame under random downstream backpressure
    rnd_ready = 1'b1;
    pix.delete();
    for (int i = 0; i < IW * IH; i++) pix.push_back(24'($urandom) & 24'h6FFFFF);
    send_pkt(4'h0, 1'b1);
    drain_compare("t4");
    check_reg("t4_vmask", 6'h21, 32'h0);
    check_reg("t4_fc",    6'h20, 32'd4);

    // Control packet with matching pixels is neither recoloured nor analysed
    mode = 1'b1;
    pix = '{24'h808080, 24'h808080, 24'h123456};
    send_pkt(4'hF, 1'b1);
    drain_compare("t5");
    check_reg("t5_fc",    6'h20, 32'd4);
    check_reg("t5_vmask", 6'h21, 32'h0);

    // Truncated frame followed by a full frame with a hit at (5,7)
    mode = 1'b0;
    pix = '{24'h808080, 24'h808080, 24'h808080};
    send_pkt(4'h0, 1'b0);
    pix.delete();
    for (int i = 0; i < IW * IH; i++) pix.push_back((i == 61) ? 24'h808080 : 24'h101010);
    send_pkt(4'h0, 1'b1);
    drain_compare("t6");
    check_reg("t6_res0_min", 6'h10, 32'h00070005);
    check_reg("t6_res0_max", 6'h11, 32'h00070005);
    check_reg("t6_vmask",    6'h21, 32'h1);
    check_reg("t6_fc",       6'h20, 32'd5);

    // Overlong frame: y holds at the last line, x keeps wrapping
    pix.delete();
    for (int i = 0; i < IW * IH + IW; i++) pix.push_back((i == 68) ? 24'h808080 : 24'h101010);
    send_pkt(4'h0, 1'b1);
    drain_compare("t7");
    check_reg("t7_res0_min", 6'h10, 32'h00070004);
    check_reg("t7_res0_max", 6'h11, 32'h00070004);
    check_reg("t7_fc",       6'h20, 32'd6);

    // Reset mid-packet, stray beats dropped, next packet flows
    send_beat(24'h000000, 1'b1, 1'b0);
    send_beat(24'h808080, 1'b0, 1'b0);
    sink_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    outq.delete();
    expq.delete();
    check("t8_valid_after_rst", {31'b0, source_valid}, 32'd0);
    check_reg("t8_fc_rst", 6'h20, 32'd0);
    check_reg("t8_lo_rst", 6'h00, 32'h00FFFFFF);
    send_beat(24'h555555, 1'b0, 1'b0);
    send_beat(24'h666666, 1'b0, 1'b1);
    sink_valid = 1'b0;
    pix = '{24'hAAAAAA, 24'hBBBBBB};
    send_pkt(4'h0, 1'b1);
    drain_compare("t8");
    check_reg("t8_fc", 6'h20, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
